tmod_responder: RTL and testbench

- Slave-side endpoint of the tmod bus.
- Accepts TMOD_OP commands and operands from the bus master and returns a TMOD_STATUS, qualified by valid/ready.
- Internally samples a raw temperature stream, keeps a moving average, tracks running max/min, and holds programmable high/low thresholds.
- Raises a sticky alarm on threshold violation.

---
 rtl/tmod_responder_pkg.sv | 29 ++
 rtl/tmod_responder_avg.sv | 53 +++++
 rtl/tmod_responder.sv | 141 ++++++++++++++
 tb/tb_tmod_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tmod_responder_pkg.sv
// Shared encodings for the tmod bus: command opcodes, response status and
// the responder's handshake states.
package tmod_responder_pkg;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_SET_HI   = 3'd1,
    OP_SET_LO   = 3'd2,
    OP_READ     = 3'd3,
    OP_READ_MAX = 3'd4,
    OP_READ_MIN = 3'd5,
    OP_CLR      = 3'd6,
    OP_CHECK    = 3'd7
  } tmod_op_e;

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_HOT  = 2'd1,
    ST_COLD = 2'd2,
    ST_ERR  = 2'd3
  } tmod_status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } tmod_fsm_e;

endpackage

// File: rtl/tmod_responder_avg.sv
// Moving average over the last 2^AVG_LOG2 temperature samples: a window
// shift register plus a running sum and a saturating fill count.
module tmod_avg
  import tmod_responder_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic [DW-1:0] temp_in,
  input  logic          temp_vld,
  output logic [DW-1:0] avg,
  output logic          full,
  output logic          upd,
  output logic [DW-1:0] avg_nxt,
  output logic          full_nxt
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int AW = DW + AVG_LOG2;
  localparam logic [AVG_LOG2:0] CNT_MAX = (AVG_LOG2 + 1)'(N);

  logic [DW-1:0]     r_win [N];
  logic [AW-1:0]     r_acc;
  logic [AVG_LOG2:0] r_cnt;
  logic [AW-1:0]     w_acc_nxt;
  logic [AVG_LOG2:0] w_cnt_nxt;

  // Sum tracks the window exactly, so the add/subtract never leaves AW bits.
  assign upd       = temp_vld & ~clr;
  assign w_acc_nxt = r_acc + AW'(temp_in) - AW'(r_win[N-1]);
  assign w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign avg       = r_acc[AW-1:AVG_LOG2];
  assign full      = (r_cnt == CNT_MAX);
  assign avg_nxt   = w_acc_nxt[AW-1:AVG_LOG2];
  assign full_nxt  = (w_cnt_nxt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      for (int i = 0; i < N; i++) r_win[i] <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (upd) begin
      r_win[0] <= temp_in;
      for (int i = 1; i < N; i++) r_win[i] <= r_win[i-1];
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/tmod_responder.sv
// tmod bus slave endpoint: three-state op handshake, programmable thresholds,
// running max/min of the raw stream and a sticky threshold alarm.
module tmod_responder
  import tmod_responder_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    op,
  input  logic [DW-1:0] opnd,
  output logic [1:0]    status,
  output logic          valid,
  output logic          ready,
  output logic [DW-1:0] rdata,
  input  logic [DW-1:0] temp_in,
  input  logic          temp_vld,
  output logic          alarm
);

  function automatic tmod_status_e classify(input logic [DW-1:0] a,
                                            input logic [DW-1:0] hi,
                                            input logic [DW-1:0] lo);
    if (a > hi) return ST_HOT;
    if (a < lo) return ST_COLD;
    return ST_OK;
  endfunction

  tmod_fsm_e    r_state, w_state_nxt;
  tmod_op_e     r_op_p0;
  logic [DW-1:0] r_opnd_p0;
  tmod_status_e r_status_p1, w_st;
  logic [DW-1:0] r_rdata_p1, w_rd;
  logic [DW-1:0] r_hi_thr, r_lo_thr, r_max, r_min;
  logic          r_seen, r_alarm;
  logic          w_accept, w_exec, w_clr, w_wr_hi, w_wr_lo;
  logic [DW-1:0] w_avg, w_avg_nxt;
  logic          w_full, w_full_nxt, w_upd;

  tmod_avg #(.DW(DW), .AVG_LOG2(AVG_LOG2)) u_avg (
    .clk      (clk),
    .reset    (reset),
    .clr      (w_clr),
    .temp_in  (temp_in),
    .temp_vld (temp_vld),
    .avg      (w_avg),
    .full     (w_full),
    .upd      (w_upd),
    .avg_nxt  (w_avg_nxt),
    .full_nxt (w_full_nxt)
  );

  assign w_accept = (r_state == S_IDLE) && (op != OP_NOP);
  assign w_exec   = (r_state == S_EXEC);
  assign w_clr    = w_exec && (r_op_p0 == OP_CLR);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (op != OP_NOP) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // p0: command capture at the accept edge
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op_p0   <= tmod_op_e'(op);
      r_opnd_p0 <= opnd;
    end
  end

  always_comb begin
    w_st    = ST_OK;
    w_rd    = '0;
    w_wr_hi = 1'b0;
    w_wr_lo = 1'b0;
    case (r_op_p0)
      OP_SET_HI:   if (r_opnd_p0 < r_lo_thr) w_st = ST_ERR; else w_wr_hi = 1'b1;
      OP_SET_LO:   if (r_opnd_p0 > r_hi_thr) w_st = ST_ERR; else w_wr_lo = 1'b1;
      OP_READ:     if (w_full) w_rd = w_avg; else w_st = ST_ERR;
      OP_READ_MAX: if (r_seen) w_rd = r_max; else w_st = ST_ERR;
      OP_READ_MIN: if (r_seen) w_rd = r_min; else w_st = ST_ERR;
      OP_CHECK: begin
        if (w_full) begin
          w_st = classify(w_avg, r_hi_thr, r_lo_thr);
          w_rd = w_avg;
        end else begin
          w_st = ST_ERR;
        end
      end
      default: ;
    endcase
  end

  // p1: execute -- results and state updates land at the EXEC->RESP edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_status_p1 <= ST_OK;
      r_rdata_p1  <= '0;
      r_hi_thr    <= '1;
      r_lo_thr    <= '0;
    end else if (w_exec) begin
      r_status_p1 <= w_st;
      r_rdata_p1  <= w_rd;
      if (w_wr_hi) r_hi_thr <= r_opnd_p0;
      if (w_wr_lo) r_lo_thr <= r_opnd_p0;
    end
  end

  // Alarm compares the incoming average against thresholds as they stood
  // before this edge, so a same-cycle SET_* does not affect it.
  always_ff @(posedge clk) begin
    if (reset || w_clr) begin
      r_max   <= '0;
      r_min   <= '1;
      r_seen  <= 1'b0;
      r_alarm <= 1'b0;
    end else if (w_upd) begin
      if (temp_in > r_max) r_max <= temp_in;
      if (temp_in < r_min) r_min <= temp_in;
      r_seen <= 1'b1;
      if (w_full_nxt && (classify(w_avg_nxt, r_hi_thr, r_lo_thr) != ST_OK))
        r_alarm <= 1'b1;
    end
  end

  assign status = r_status_p1;
  assign rdata  = r_rdata_p1;
  assign valid  = (r_state == S_RESP);
  assign ready  = (r_state == S_IDLE);
  assign alarm  = r_alarm;

endmodule

// File: tb/tb_tmod_responder.sv
// Directed bench for tmod_responder: op handshake timing, thresholds,
// averaging, max/min, alarm and the collision/abort cases.
module tb_tmod_responder;
  import tmod_responder_pkg::*;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    op;
  logic [DW-1:0] opnd;
  logic [1:0]    status;
  logic          valid, ready;
  logic [DW-1:0] rdata;
  logic [DW-1:0] temp_in;
  logic          temp_vld;
  logic          alarm;

  int n_chk  = 0;
  int n_fail = 0;

  tmod_responder #(.DW(DW), .AVG_LOG2(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .opnd     (opnd),
    .status   (status),
    .valid    (valid),
    .ready    (ready),
    .rdata    (rdata),
    .temp_in  (temp_in),
    .temp_vld (temp_vld),
    .alarm    (alarm)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; op = OP_NOP; opnd = '0; temp_in = '0; temp_vld = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic feed(input logic [DW-1:0] v);
    temp_in = v; temp_vld = 1'b1;
    tick();
    temp_vld = 1'b0;
  endtask

  // Issues one op and returns what was seen in the EXEC and RESP cycles.
  task automatic do_op(input logic [2:0] o, input logic [DW-1:0] d,
                       output logic [1:0] st, output logic [DW-1:0] rd,
                       output logic v_exec, output logic v_resp, output logic rdy);
    int k = 0;
    while (ready !== 1'b1 && k < 20) begin tick(); k++; end
    rdy = ready;
    op = o; opnd = d;
    tick();
    op = OP_NOP;
    v_exec = valid;
    tick();
    v_resp = valid; st = status; rd = rdata;
    tick();
  endtask

  task automatic test_reset();
    logic [1:0] st; logic [DW-1:0] rd; logic ve, vr, rdy;
    do_reset();
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", ready); end
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", valid); end
    n_chk++; if (status !== ST_OK) begin n_fail++; $display("FAIL reset_status got %0d want 0", status); end
    n_chk++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL reset_alarm got %0b want 0", alarm); end
    n_chk++; if (rdata !== 8'd0) begin n_fail++; $display("FAIL reset_rdata got %0d want 0", rdata); end
    do_op(OP_READ, 8'd0, st, rd, ve, vr, rdy);
    n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL read_ready_timeout got %0b want 1", rdy); end
    n_chk++; if (ve !== 1'b0 || vr !== 1'b1) begin n_fail++; $display("FAIL read_latency got exec=%0b resp=%0b want 0/1", ve, vr); end
    n_chk++; if (st !== ST_ERR || rd !== 8'd0) begin n_fail++; $display("FAIL read_empty got st=%0d rd=%0d want 3/0", st, rd); end
    n_chk++; if (valid !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL read_return got valid=%0b ready=%0b want 0/1", valid, ready); end
  endtask

  task automatic test_avg();
    logic [1:0] st; logic [DW-1:0] rd; logic ve, vr, rdy;
    do_reset();
    feed(8'd10); feed(8'd20); feed(8'd30); feed(8'd40);
    do_op(OP_READ, 8'd0, st, rd, ve, vr, rdy);
    n_chk++; if (st !== ST_OK || rd !== 8'd25) begin n_fail++; $display("FAIL avg_read got st=%0d rd=%0d want 0/25", st, rd); end
    do_op(OP_READ_MAX, 8'd0, st, rd, ve, vr, rdy);
    n_chk++; if (st !== ST_OK || rd !== 8'd40) begin n_fail++; $display("FAIL read_max got st=%0d rd=%0d want 0/40", st, rd); end
    do_op(OP_READ_MIN, 8'd0, st, rd, ve, vr, rdy);
    n_chk++; if (st !== ST_OK || rd !== 8'd10) begin n_fail++; $display("FAIL read_min got st=%0d rd=%0d want 0/10", st, rd); end
    feed(8'd50);
    do_op(OP_READ, 8'd0, st, rd, ve, vr, rdy);
    n_chk++; if (st !== ST_OK || rd !== 8'd35) begin n_fail++; $display("FAIL avg_slide got st=%0d rd=%0d want 0/35", st, rd); end
  endtask

  task automatic test_thresh();
    logic [1:0] st; logic [DW-1:0] rd; logic ve, vr, rdy;
    do_reset();
    do_op(OP_SET_LO, 8'd50, st, rd, ve, vr, rdy);
    n_chk++; if (st !== ST_OK || rd !== 8'd0) begin n_fail++; $display("FAIL set_lo50 got st=%0d rd=%0d want 0/0", st, rd); end
    do_op(OP_SET_HI, 8'd40, st, rd, ve, vr, rdy);
    n_chk++; if (st !== ST_ERR) begin n_fail++; $display("FAIL set_hi_below_lo got st=%0d want 3", st); end
    feed(8'd200); feed(8'd200); feed(8'd200); feed(8'd200);
    n_chk++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL hi_kept_alarm got %0b want 0", alarm); end
    do_op(OP_CHECK, 8'd0, st, rd, ve, vr, rdy);
    n_chk++; if (st !== ST_OK || rd !== 8'd200) begin n_fail++; $display("FAIL hi_kept_check got st=%0d rd=%0d want 0/200", st, rd); end
    do_op(OP_SET_HI, 8'd50, st, rd, ve, vr, rdy);
    n_chk++; if (st !== ST_OK) begin n_fail++; $display("FAIL set_hi_equal got st=%0d want 0", st); end
    do_op(OP_CHECK, 8'd0, st, rd, ve, vr, rdy);
    n_chk++; if (st !== ST_HOT || rd !== 8'd200) begin n_fail++; $display("FAIL check_after_hi got st=%0d rd=%0d want 1/200", st, rd); end
  endtask

  task automatic test_alarm();
    logic [1:0] st; logic [DW-1:0] rd; logic ve, vr, rdy;
    do_reset();
    do_op(OP_SET_HI, 8'd30, st, rd, ve, vr, rdy);
    n_chk++; if (st !== ST_OK) begin n_fail++; $display("FAIL set_hi30 got st=%0d want 0", st); end
    feed(8'd40); feed(8'd40); feed(8'd40);
    n_chk++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL alarm_early got %0b want 0", alarm); end
    feed(8'd40);
    n_chk++; if (alarm !== 1'b1) begin n_fail++; $display("FAIL alarm_set got %0b want 1", alarm); end
    do_op(OP_CHECK, 8'd0, st, rd, ve, vr, rdy);
    n_chk++; if (st !== ST_HOT || rd !== 8'd40) begin n_fail++; $display("FAIL check_hot got st=%0d rd=%0d want 1/40", st, rd); end
    n_chk++; if (alarm !== 1'b1) begin n_fail++; $display("FAIL alarm_sticky got %0b want 1", alarm); end
    do_op(OP_CLR, 8'd0, st, rd, ve, vr, rdy);
    n_chk++; if (st !== ST_OK || alarm !== 1'b0) begin n_fail++; $display("FAIL clr got st=%0d alarm=%0b want 0/0", st, alarm); end
    do_op(OP_READ, 8'd0, st, rd, ve, vr, rdy);
    n_chk++; if (st !== ST_ERR || rd !== 8'd0) begin n_fail++; $display("FAIL read_after_clr got st=%0d rd=%0d want 3/0", st, rd); end
    do_op(OP_READ_MAX, 8'd0, st, rd, ve, vr, rdy);
    n_chk++; if (st !== ST_ERR || rd !== 8'd0) begin n_fail++; $display("FAIL max_after_clr got st=%0d rd=%0d want 3/0", st, rd); end
  endtask

  task automatic test_cold();
    logic [1:0] st; logic [DW-1:0] rd; logic ve, vr, rdy;
    do_reset();
    do_op(OP_SET_LO, 8'd20, st, rd, ve, vr, rdy);
    feed(8'd0); feed(8'd0); feed(8'd0); feed(8'd4);
    n_chk++; if (alarm !== 1'b1) begin n_fail++; $display("FAIL cold_alarm got %0b want 1", alarm); end
    do_op(OP_CHECK, 8'd0, st, rd, ve, vr, rdy);
    n_chk++; if (st !== ST_COLD || rd !== 8'd1) begin n_fail++; $display("FAIL check_cold got st=%0d rd=%0d want 2/1", st, rd); end
  endtask

  task automatic test_ignore();
    logic [1:0] st; logic [DW-1:0] rd; logic ve, vr, rdy;
    do_reset();
    feed(8'd8); feed(8'd8); feed(8'd8); feed(8'd8);
    op = OP_SET_HI; opnd = 8'd100;
    tick();
    op = OP_SET_LO; opnd = 8'd200;
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL exec_ready got %0b want 0", ready); end
    tick();
    op = OP_CLR;
    n_chk++; if (valid !== 1'b1 || status !== ST_OK) begin n_fail++; $display("FAIL ign_resp got valid=%0b st=%0d want 1/0", valid, status); end
    tick();
    op = OP_NOP;
    tick();
    n_chk++; if (ready !== 1'b1 || valid !== 1'b0) begin n_fail++; $display("FAIL ign_no_accept got ready=%0b valid=%0b want 1/0", ready, valid); end
    do_op(OP_CHECK, 8'd0, st, rd, ve, vr, rdy);
    n_chk++; if (st !== ST_OK || rd !== 8'd8) begin n_fail++; $display("FAIL ign_check got st=%0d rd=%0d want 0/8", st, rd); end
    do_op(OP_SET_LO, 8'd101, st, rd, ve, vr, rdy);
    n_chk++; if (st !== ST_ERR) begin n_fail++; $display("FAIL ign_hi100 got st=%0d want 3", st); end
  endtask

  task automatic test_clr_collision();
    logic [1:0] st; logic [DW-1:0] rd; logic ve, vr, rdy;
    do_reset();
    feed(8'd50); feed(8'd60);
    op = OP_CLR;
    tick();
    op = OP_NOP; temp_in = 8'd99; temp_vld = 1'b1;
    tick();
    temp_vld = 1'b0;
    tick();
    do_op(OP_READ_MAX, 8'd0, st, rd, ve, vr, rdy);
    n_chk++; if (st !== ST_ERR || rd !== 8'd0) begin n_fail++; $display("FAIL clr_drop_max got st=%0d rd=%0d want 3/0", st, rd); end
    feed(8'd12); feed(8'd12); feed(8'd12); feed(8'd12);
    do_op(OP_READ, 8'd0, st, rd, ve, vr, rdy);
    n_chk++; if (st !== ST_OK || rd !== 8'd12) begin n_fail++; $display("FAIL clr_window got st=%0d rd=%0d want 0/12", st, rd); end
  endtask

  task automatic test_reset_mid();
    logic seen_valid = 1'b0;
    do_reset();
    op = OP_READ_MAX;
    tick();
    op = OP_NOP;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_chk++; if (ready !== 1'b1 || valid !== 1'b0) begin n_fail++; $display("FAIL abort_state got ready=%0b valid=%0b want 1/0", ready, valid); end
    for (int i = 0; i < 4; i++) begin
      if (valid === 1'b1) seen_valid = 1'b1;
      tick();
    end
    n_chk++; if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %0b want 0", seen_valid); end
  endtask

  initial begin
    reset = 1'b1; op = OP_NOP; opnd = '0; temp_in = '0; temp_vld = 1'b0;
    test_reset();
    test_avg();
    test_thresh();
    test_alarm();
    test_cold();
    test_ignore();
    test_clr_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
